// File: rtl/eth_frame_gen_pkg.sv
// eth_frame_gen shared types and constants.
// State encoding, Ethernet length limits, length clamp helper.
package eth_frame_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam int ETH_HDR_LEN     = 14;
  localparam int ETH_MIN_PAYLOAD = 46;
  localparam int ETH_MAX_PAYLOAD = 1500;

  localparam int C_DEF_MIN_LEN =
    ETH_HDR_LEN + ETH_MIN_PAYLOAD;
  localparam int C_DEF_MAX_LEN =
    ETH_HDR_LEN + ETH_MAX_PAYLOAD;

  function automatic logic [10:0] clamp_len(
    input logic [10:0] len,
    input logic [10:0] lo,
    input logic [10:0] hi
  );
    if (len < lo)      return lo;
    else if (len > hi) return hi;
    else               return len;
  endfunction

endpackage

// File: rtl/eth_frame_gen_cnt.sv
// Wrapping statistics counter with increment and clear.
// Ports: clk, rst, inc_i, clr_i (wins over inc_i), cnt_o.
module eth_frame_gen_cnt #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst || clr_i) cnt_q <= '0;
    else if (inc_i)   cnt_q <= cnt_q + 1'b1;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/eth_frame_gen.sv
// Byte-wide AXI4-Stream test frame generator.
// Ports: run control in, AXIS tx out, busy/done, frame/byte stats.
module eth_frame_gen
  import eth_frame_gen_pkg::*;
#(
  parameter int C_MIN_LEN   = C_DEF_MIN_LEN,
  parameter int C_MAX_LEN   = C_DEF_MAX_LEN,
  parameter int C_CNT_WIDTH = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic [10:0]            frame_len,
  input  logic [15:0]            frame_gap,
  input  logic [31:0]            frame_count,
  input  logic                   clear_stats,
  input  logic                   axis_tx_tready,
  output logic                   axis_tx_tvalid,
  output logic                   axis_tx_tlast,
  output logic [7:0]             axis_tx_tdata,
  output logic                   busy,
  output logic                   done,
  output logic [C_CNT_WIDTH-1:0] frames_sent,
  output logic [C_CNT_WIDTH-1:0] bytes_sent
);

  state_e      state_q;
  logic [10:0] len_q;
  logic [10:0] idx_q;
  logic [15:0] gap_q;
  logic [31:0] run_q;
  // Only the low byte of the frame sequence number is visible.
  logic [7:0]  seq_q;
  logic        tvalid_q;
  logic        tlast_q;
  logic [7:0]  tdata_q;
  logic        busy_q;
  logic        done_q;

  logic        hs;
  logic        last_hs;
  logic [31:0] run_inc;
  logic [10:0] len_cl;
  logic        run_end;

  assign hs      = tvalid_q & axis_tx_tready;
  assign last_hs = hs & tlast_q;
  assign run_inc = run_q + 32'd1;
  assign len_cl  = clamp_len(frame_len,
                             11'(C_MIN_LEN),
                             11'(C_MAX_LEN));
  assign run_end = (frame_count != 32'd0) &&
                   (run_inc == frame_count);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      len_q    <= '0;
      idx_q    <= '0;
      gap_q    <= '0;
      run_q    <= '0;
      seq_q    <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      tdata_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (enable) begin
            state_q  <= ST_SEND;
            len_q    <= len_cl;
            idx_q    <= '0;
            run_q    <= '0;
            tvalid_q <= 1'b1;
            tdata_q  <= seq_q;
            tlast_q  <= (len_cl == 11'd1);
            busy_q   <= 1'b1;
          end
        end
        ST_SEND: begin
          if (last_hs) begin
            run_q <= run_inc;
            seq_q <= seq_q + 8'd1;
            gap_q <= frame_gap;
            if (run_end) begin
              state_q  <= ST_DONE;
              tvalid_q <= 1'b0;
              tlast_q  <= 1'b0;
              busy_q   <= 1'b0;
              done_q   <= 1'b1;
            end else if (!enable) begin
              state_q  <= ST_IDLE;
              tvalid_q <= 1'b0;
              tlast_q  <= 1'b0;
              busy_q   <= 1'b0;
            end else if (frame_gap == 16'd0) begin
              len_q   <= len_cl;
              idx_q   <= '0;
              tdata_q <= seq_q + 8'd1;
              tlast_q <= (len_cl == 11'd1);
            end else begin
              state_q  <= ST_GAP;
              tvalid_q <= 1'b0;
              tlast_q  <= 1'b0;
            end
          end else if (hs) begin
            idx_q   <= idx_q + 11'd1;
            tdata_q <= tdata_q + 8'd1;
            // Next beat is last when idx+1 == len-1.
            tlast_q <= (idx_q + 11'd2 == len_q);
          end
        end
        ST_GAP: begin
          if (!enable) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else if (gap_q == 16'd1) begin
            // Raise tvalid so it is seen exactly gap cycles later.
            state_q  <= ST_SEND;
            len_q    <= len_cl;
            idx_q    <= '0;
            tvalid_q <= 1'b1;
            tdata_q  <= seq_q;
            tlast_q  <= (len_cl == 11'd1);
          end else begin
            gap_q <= gap_q - 16'd1;
          end
        end
        ST_DONE: begin
          if (!enable) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b0;
          end
        end
      endcase
    end
  end

  eth_frame_gen_cnt #(.W(C_CNT_WIDTH)) u_frames (
    .clk   (clk),
    .rst   (rst),
    .inc_i (last_hs),
    .clr_i (clear_stats),
    .cnt_o (frames_sent)
  );

  eth_frame_gen_cnt #(.W(C_CNT_WIDTH)) u_bytes (
    .clk   (clk),
    .rst   (rst),
    .inc_i (hs),
    .clr_i (clear_stats),
    .cnt_o (bytes_sent)
  );

  assign axis_tx_tvalid = tvalid_q;
  assign axis_tx_tlast  = tlast_q;
  assign axis_tx_tdata  = tdata_q;
  assign busy           = busy_q;
  assign done           = done_q;

endmodule

// File: tb/tb_eth_frame_gen.sv
// Directed bench for eth_frame_gen with a beat scoreboard.
// Ports: drives run control and tready, monitors AXIS and stats.
module tb_eth_frame_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [10:0] frame_len = 11'd60;
  logic [15:0] frame_gap = 16'd0;
  logic [31:0] frame_count = 32'd1;
  logic        clear_stats = 1'b0;
  logic        tready = 1'b1;
  logic        tvalid;
  logic        tlast;
  logic [7:0]  tdata;
  logic        busy;
  logic        done;
  logic [63:0] frames_sent;
  logic [63:0] bytes_sent;

  int errors = 0;
  int checks = 0;

  logic [8:0] exp_q[$];
  int         gaps_q[$];
  int         hs_cnt = 0;
  logic [7:0] seq_m = 8'd0;
  bit         rnd = 1'b0;

  bit         armed = 1'b0;
  int         idle_cnt = 0;
  bit         stall_prev = 1'b0;
  logic [7:0] pd = 8'd0;
  logic       pl = 1'b0;

  eth_frame_gen dut (
    .clk            (clk),
    .rst            (rst),
    .enable         (enable),
    .frame_len      (frame_len),
    .frame_gap      (frame_gap),
    .frame_count    (frame_count),
    .clear_stats    (clear_stats),
    .axis_tx_tready (tready),
    .axis_tx_tvalid (tvalid),
    .axis_tx_tlast  (tlast),
    .axis_tx_tdata  (tdata),
    .busy           (busy),
    .done           (done),
    .frames_sent    (frames_sent),
    .bytes_sent     (bytes_sent)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  // Monitor: scoreboard pops, hold-while-stalled, gap length.
  initial begin
    logic [8:0] e;
    forever begin
      @(negedge clk);
      if (rst) begin
        armed      = 1'b0;
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) begin
          chk("hold_valid", 64'(tvalid), 64'd1);
          chk("hold_data", 64'(tdata), 64'(pd));
          chk("hold_last", 64'(tlast), 64'(pl));
        end
        if (armed) begin
          if (!busy) armed = 1'b0;
          else if (tvalid) begin
            gaps_q.push_back(idle_cnt);
            armed = 1'b0;
          end else idle_cnt++;
        end
        if (tvalid && tready) begin
          hs_cnt++;
          chk("sb_nonempty",
              64'(exp_q.size() > 0), 64'd1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("beat_data", 64'(tdata), 64'(e[7:0]));
            chk("beat_last", 64'(tlast), 64'(e[8]));
          end
          if (tlast) begin
            armed    = 1'b1;
            idle_cnt = 0;
          end
        end
        stall_prev = tvalid && !tready;
        pd = tdata;
        pl = tlast;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_frame(input int len);
    for (int i = 0; i < len; i++)
      exp_q.push_back({(i == len - 1), 8'(seq_m + i)});
    seq_m = seq_m + 8'd1;
  endtask

  task automatic clear_pulse();
    clear_stats = 1'b1;
    step(1);
    clear_stats = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int bound);
    int n = 0;
    while (!done && n < bound) begin
      @(posedge clk);
      #1;
      if (rnd) tready = 1'($urandom_range(0, 1));
      n++;
    end
    tready = 1'b1;
    chk({tag, "_done"}, 64'(done), 64'd1);
  endtask

  task automatic wait_idle(input string tag, input int bound);
    int n = 0;
    while ((busy || tvalid) && n < bound) begin
      step(1);
      n++;
    end
    chk({tag, "_idle"}, 64'(busy || tvalid), 64'd0);
  endtask

  task automatic wait_hs(input string tag, input int cnt);
    int n = 0;
    int base = hs_cnt;
    while ((hs_cnt - base) < cnt && n < 500) begin
      step(1);
      n++;
    end
    chk({tag, "_hs"}, 64'((hs_cnt - base) >= cnt), 64'd1);
  endtask

  initial begin
    int n;
    // Reset state
    step(3);
    chk("rst_tvalid", 64'(tvalid), 64'd0);
    chk("rst_tlast", 64'(tlast), 64'd0);
    chk("rst_tdata", 64'(tdata), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_frames", frames_sent, 64'd0);
    chk("rst_bytes", bytes_sent, 64'd0);
    rst = 1'b0;
    step(1);

    // Basic single frame
    frame_len = 11'd60; frame_gap = 16'd0; frame_count = 32'd1;
    push_frame(60);
    enable = 1'b1;
    wait_done("t1", 300);
    chk("t1_frames", frames_sent, 64'd1);
    chk("t1_bytes", bytes_sent, 64'd60);
    chk("t1_tvalid", 64'(tvalid), 64'd0);
    chk("t1_sb_empty", 64'(exp_q.size()), 64'd0);
    enable = 1'b0;
    step(2);
    chk("t1_done_clr", 64'(done), 64'd0);

    // Gap timing
    clear_pulse();
    chk("t2_clr_frames", frames_sent, 64'd0);
    chk("t2_clr_bytes", bytes_sent, 64'd0);
    gaps_q.delete();
    frame_len = 11'd64; frame_gap = 16'd5; frame_count = 32'd3;
    for (int f = 0; f < 3; f++) push_frame(64);
    enable = 1'b1;
    wait_done("t2", 600);
    enable = 1'b0;
    step(2);
    chk("t2_ngaps", 64'(gaps_q.size()), 64'd2);
    if (gaps_q.size() == 2) begin
      chk("t2_gap0", 64'(gaps_q[0]), 64'd5);
      chk("t2_gap1", 64'(gaps_q[1]), 64'd5);
    end
    chk("t2_frames", frames_sent, 64'd3);
    chk("t2_bytes", bytes_sent, 64'd192);
    chk("t2_sb_empty", 64'(exp_q.size()), 64'd0);

    // Back-pressure
    clear_pulse();
    frame_len = 11'd100; frame_gap = 16'd3; frame_count = 32'd2;
    push_frame(100);
    push_frame(100);
    rnd = 1'b1;
    enable = 1'b1;
    wait_done("t3", 2000);
    rnd = 1'b0;
    enable = 1'b0;
    step(2);
    chk("t3_frames", frames_sent, 64'd2);
    chk("t3_bytes", bytes_sent, 64'd200);
    chk("t3_sb_empty", 64'(exp_q.size()), 64'd0);

    // Clamp low, back-to-back
    clear_pulse();
    gaps_q.delete();
    frame_len = 11'd10; frame_gap = 16'd0; frame_count = 32'd2;
    push_frame(60);
    push_frame(60);
    enable = 1'b1;
    wait_done("t4a", 400);
    enable = 1'b0;
    step(2);
    chk("t4a_bytes", bytes_sent, 64'd120);
    chk("t4a_ngaps", 64'(gaps_q.size()), 64'd1);
    if (gaps_q.size() == 1)
      chk("t4a_gap0", 64'(gaps_q[0]), 64'd0);

    // Clamp high
    clear_pulse();
    frame_len = 11'd2000; frame_count = 32'd1;
    push_frame(1514);
    enable = 1'b1;
    wait_done("t4b", 2000);
    enable = 1'b0;
    step(2);
    chk("t4b_bytes", bytes_sent, 64'd1514);
    chk("t4b_sb_empty", 64'(exp_q.size()), 64'd0);

    // Enable dropped mid-frame
    clear_pulse();
    frame_len = 11'd60; frame_gap = 16'd2; frame_count = 32'd0;
    push_frame(60);
    enable = 1'b1;
    wait_hs("t5", 20);
    enable = 1'b0;
    wait_idle("t5", 200);
    step(3);
    chk("t5_tvalid", 64'(tvalid), 64'd0);
    chk("t5_done", 64'(done), 64'd0);
    chk("t5_frames", frames_sent, 64'd1);
    chk("t5_bytes", bytes_sent, 64'd60);
    chk("t5_sb_empty", 64'(exp_q.size()), 64'd0);

    // Clear colliding with last-beat handshake
    frame_gap = 16'd0; frame_count = 32'd1;
    push_frame(60);
    enable = 1'b1;
    n = 0;
    while (!(tvalid && tlast) && n < 300) begin
      step(1);
      n++;
    end
    chk("t5c_found_last", 64'(tvalid && tlast), 64'd1);
    clear_stats = 1'b1;
    step(1);
    clear_stats = 1'b0;
    chk("t5c_frames", frames_sent, 64'd0);
    chk("t5c_bytes", bytes_sent, 64'd0);
    chk("t5c_done", 64'(done), 64'd1);
    enable = 1'b0;
    step(2);

    // Reset mid-frame
    frame_count = 32'd0;
    push_frame(60);
    enable = 1'b1;
    wait_hs("t6", 30);
    rst = 1'b1;
    enable = 1'b0;
    step(1);
    chk("t6_tvalid", 64'(tvalid), 64'd0);
    chk("t6_busy", 64'(busy), 64'd0);
    chk("t6_frames", frames_sent, 64'd0);
    chk("t6_bytes", bytes_sent, 64'd0);
    exp_q.delete();
    seq_m = 8'd0;
    rst = 1'b0;
    step(1);
    frame_count = 32'd1;
    push_frame(60);
    enable = 1'b1;
    wait_done("t6", 300);
    enable = 1'b0;
    step(2);
    chk("t6_frames2", frames_sent, 64'd1);
    chk("t6_bytes2", bytes_sent, 64'd60);
    chk("t6_sb_empty", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
